bram_to_axis_mover: RTL and testbench

BRAM_TO_AXIS_MOVER -- requirements
Module: bram_to_axis_mover

---
 rtl/bram_to_axis_mover_pkg.sv | 14 +
 rtl/bram_to_axis_mover_if.sv | 29 ++
 rtl/axis_skid_fifo.sv | 57 +++++
 rtl/bram_to_axis_mover.sv | 149 ++++++++++++++
 tb/tb_bram_to_axis_mover.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_to_axis_mover_pkg.sv
// Shared constants and FSM encoding for the BRAM-to-AXI-Stream mover.
package bram_to_axis_mover_pkg;

    localparam int unsigned DEF_DWIDTH   = 32;
    localparam int unsigned DEF_AWIDTH   = 12;
    localparam int unsigned DEF_MEM_SIZE = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bram_to_axis_mover_if.sv
// BRAM read port plus AXI4-Stream master bundle; master = mover side.
interface bram_to_axis_mover_if
    import bram_to_axis_mover_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
);

    logic [AWIDTH-1:0] addr_b;
    logic              ce_b;
    logic              we_b;
    logic [DWIDTH-1:0] d_b;
    logic [DWIDTH-1:0] q_b;
    logic              m_tvalid;
    logic              m_tready;
    logic [DWIDTH-1:0] m_tdata;
    logic              m_tlast;

    modport master (
        output addr_b, ce_b, we_b, d_b, m_tvalid, m_tdata, m_tlast,
        input  q_b, m_tready
    );

    modport slave (
        input  addr_b, ce_b, we_b, d_b, m_tvalid, m_tdata, m_tlast,
        output q_b, m_tready
    );

endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO whose head register drives the stream output directly.
module axis_skid_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign dout    = head_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) head_q <= din;
                    else       tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind any waiting one.
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_to_axis_mover.sv
// Streams BRAM words 0..num_cnt-1 out on AXI4-Stream.
// Define BRAM_TO_AXIS_TLAST_EN to drive m_tlast on the final beat (tied 0 otherwise).
module bram_to_axis_mover
    import bram_to_axis_mover_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned AWIDTH   = DEF_AWIDTH,
    parameter int unsigned MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_done,
    bram_to_axis_mover_if.master bus
);

`ifdef BRAM_TO_AXIS_TLAST_EN
    localparam int unsigned FW = DWIDTH + 1;
`else
    localparam int unsigned FW = DWIDTH;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [AWIDTH-1:0] last_q;
    logic [AWIDTH-1:0] rd_addr_q;
    logic [AWIDTH-1:0] beat_q;
    logic [AWIDTH-1:0] num_last;
    logic              zero_q;
    logic              rd_done_q;
    logic              rd_vld_q;
    logic              issue;
    logic              hs;
    logic              final_beat;
    logic              start;
    logic              full;
    logic              empty;
    logic [1:0]        occ_after;
    logic [2:0]        committed;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;

    assign start      = (state_q == ST_IDLE) & i_run;
    assign hs         = ~empty & bus.m_tready;
    assign final_beat = (beat_q == last_q);

    // Last address of the transfer, clamped to the BRAM depth.
    always_comb begin
        num_last = i_num_cnt - AWIDTH'(1);
        if (32'(num_last) > MEM_SIZE - 1) num_last = AWIDTH'(MEM_SIZE - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            o_idle  <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_idle  <= (state_d == ST_IDLE);
            o_busy  <= (state_d == ST_RUN);
            o_done  <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_run) state_d = ST_RUN;
            ST_RUN:  if (zero_q || (hs && final_beat)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue a read only when its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        occ_after = (full ? 2'd2 : (empty ? 2'd0 : 2'd1)) - {1'b0, hs};
        committed = {1'b0, occ_after} + {2'b00, rd_vld_q};
        issue     = 1'b0;
        if ((state_q == ST_RUN) && !rd_done_q && (committed < 3'd2)) issue = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= '0;
            rd_addr_q <= '0;
            beat_q    <= '0;
            zero_q    <= 1'b0;
            rd_done_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= issue;
            if (start) begin
                last_q    <= num_last;
                zero_q    <= (i_num_cnt == '0);
                rd_done_q <= (i_num_cnt == '0);
                rd_addr_q <= '0;
                beat_q    <= '0;
            end else if (state_q == ST_DONE) begin
                rd_addr_q <= '0;
            end else begin
                if (issue) begin
                    if (rd_addr_q == last_q) rd_done_q <= 1'b1;
                    else                     rd_addr_q <= rd_addr_q + AWIDTH'(1);
                end
                if (hs && !final_beat) beat_q <= beat_q + AWIDTH'(1);
            end
        end
    end

`ifdef BRAM_TO_AXIS_TLAST_EN
    logic rd_last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_last_q <= 1'b0;
        else          rd_last_q <= issue & (rd_addr_q == last_q);
    end

    assign fifo_din    = {rd_last_q, bus.q_b};
    assign bus.m_tlast = fifo_dout[DWIDTH];
`else
    assign fifo_din    = bus.q_b;
    assign bus.m_tlast = 1'b0;
`endif

    axis_skid_fifo #(.WIDTH(FW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rd_vld_q),
        .din     (fifo_din),
        .pop     (hs),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (empty)
    );

    assign bus.addr_b   = rd_addr_q;
    assign bus.ce_b     = issue;
    assign bus.we_b     = 1'b0;
    assign bus.d_b      = '0;
    assign bus.m_tvalid = ~empty;
    assign bus.m_tdata  = fifo_dout[DWIDTH-1:0];

endmodule

// File: tb/tb_bram_to_axis_mover.sv
// Directed bench for bram_to_axis_mover with a BRAM model and a stream monitor.
module tb_bram_to_axis_mover;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          i_run     = 1'b0;
    logic [AW-1:0] i_num_cnt = '0;
    logic          o_idle;
    logic          o_busy;
    logic          o_done;

    bram_to_axis_mover_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    bram_to_axis_mover #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(4096)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (i_run),
        .i_num_cnt (i_num_cnt),
        .o_idle    (o_idle),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency.
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] q_r = '0;
    always @(posedge clk) if (bus.ce_b) q_r <= mem[bus.addr_b];
    assign bus.q_b = q_r;

    // Stream/BRAM observer, sampled on the falling edge.
    logic          mon_clr = 1'b1;
    logic [DW-1:0] beat_dq[$];
    logic          beat_lq[$];
    int valid_cnt, ce_cnt, stab_bad, ce_bad, addr_bad, issued, popped;
    int done_cnt, first_cyc, last_cyc, done_cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (mon_clr) begin
            beat_dq.delete(); beat_lq.delete();
            valid_cnt = 0; ce_cnt = 0; stab_bad = 0; ce_bad = 0; addr_bad = 0;
            issued = 0; popped = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
            prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        end else begin
            if (bus.m_tvalid) valid_cnt++;
            if (prev_stall && (!bus.m_tvalid || bus.m_tdata !== prev_data || bus.m_tlast !== prev_last))
                stab_bad++;
            if (bus.m_tvalid && bus.m_tready) begin
                popped++;
                beat_dq.push_back(bus.m_tdata);
                beat_lq.push_back(bus.m_tlast);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (bus.ce_b) begin
                ce_cnt++;
                if (32'(bus.addr_b) != 32'(issued)) addr_bad++;
                if (issued - popped >= 2) ce_bad++;
                issued++;
            end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic start(input int n, output int rc);
        i_num_cnt = AW'(n);
        i_run     = 1'b1;
        rc        = cyc;
        tick();
        i_run     = 1'b0;
        i_num_cnt = AW'(5);
    endtask

    // pat 0: tready held high; pat 1: tready 1,0,0,1 repeating.
    task automatic run_until_done(input int pat, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            bus.m_tready = (pat == 0) || (k % 4 == 0) || (k % 4 == 3);
            tick();
            k++;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        bus.m_tready = 1'b1;
        tick(); tick();
        chk("done_width", 32'(done_cnt), 32'd1);
        chk("idle_after", 32'(o_idle), 32'd1);
        chk("busy_after", 32'(o_busy), 32'd0);
    endtask

    task automatic check_transfer(input string tag, input int n);
        logic exp_last;
        chk({tag, "_nbeats"}, 32'(beat_dq.size()), 32'(n));
        chk({tag, "_nreads"}, 32'(ce_cnt), 32'(n));
        chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
        chk({tag, "_ce_rule"}, 32'(ce_bad), 32'd0);
        chk({tag, "_addr_seq"}, 32'(addr_bad), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i < beat_dq.size()) begin
`ifdef BRAM_TO_AXIS_TLAST_EN
                exp_last = (i == n - 1);
`else
                exp_last = 1'b0;
`endif
                chk($sformatf("%s_data%0d", tag, i), beat_dq[i], 32'(100 + i));
                chk($sformatf("%s_last%0d", tag, i), 32'(beat_lq[i]), 32'(exp_last));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"},   32'(o_idle),       32'd1);
        chk({tag, "_busy"},   32'(o_busy),       32'd0);
        chk({tag, "_done"},   32'(o_done),       32'd0);
        chk({tag, "_ce"},     32'(bus.ce_b),     32'd0);
        chk({tag, "_addr"},   32'(bus.addr_b),   32'd0);
        chk({tag, "_tvalid"}, 32'(bus.m_tvalid), 32'd0);
        chk({tag, "_tdata"},  bus.m_tdata,       32'd0);
        chk({tag, "_tlast"},  32'(bus.m_tlast),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc;
        int k;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 100);
        bus.m_tready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // Eight words, sink always ready: back-to-back beats, fixed latency.
        clear_mon();
        bus.m_tready = 1'b1;
        start(8, rc);
        chk("a_busy", 32'(o_busy), 32'd1);
        run_until_done(0, 60);
        check_transfer("a", 8);
        chk("a_first_lat", 32'(first_cyc - rc), 32'd3);
        chk("a_span", 32'(last_cyc - first_cyc), 32'd7);
        chk("a_done_lat", 32'(done_cyc - last_cyc), 32'd1);

        // Sixteen words with a stalling sink.
        clear_mon();
        start(16, rc);
        run_until_done(1, 200);
        check_transfer("b", 16);

        // Zero-length transfer.
        clear_mon();
        start(0, rc);
        chk("z_busy", 32'(o_busy), 32'd1);
        run_until_done(0, 20);
        chk("z_reads", 32'(ce_cnt), 32'd0);
        chk("z_valid", 32'(valid_cnt), 32'd0);
        chk("z_done_lat", 32'(done_cyc - rc), 32'd2);

        // Single word.
        clear_mon();
        start(1, rc);
        run_until_done(0, 30);
        check_transfer("s", 1);

        // Reset in the middle of a ten-word transfer.
        clear_mon();
        bus.m_tready = 1'b1;
        start(10, rc);
        k = 0;
        while (beat_dq.size() < 3 && k < 50) begin tick(); k++; end
        chk("r_pre_beats", 32'(beat_dq.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("r_mid");
        tick(); tick();
        reset_n = 1'b1;
        clear_mon();
        repeat (4) tick();
        chk("r_no_residual", 32'(valid_cnt), 32'd0);
        chk("r_no_reads", 32'(ce_cnt), 32'd0);
        chk("r_idle", 32'(o_idle), 32'd1);
        start(4, rc);
        run_until_done(0, 40);
        check_transfer("r", 4);

        // Second start pulse during RUN must be ignored.
        clear_mon();
        start(10, rc);
        tick(); tick();
        i_run = 1'b1; i_num_cnt = AW'(5);
        tick();
        i_run = 1'b0;
        run_until_done(0, 100);
        check_transfer("p", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
